// File: rtl/s2p_pkg.sv
// -----------------------------------------------------------------------------
// s2p_pkg : shared types and helpers for the s2p serial-to-parallel receiver.
//   state_e : receiver FSM states. PARITY exists only when S2P_PARITY_EN is
//             defined (optional trailing even-parity bit per word).
//   cnt_w() : bit-counter width for a given word width.
// -----------------------------------------------------------------------------
package s2p_pkg;

`ifdef S2P_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_e;
`endif

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/s2p_if.sv
// -----------------------------------------------------------------------------
// s2p_if : serial input strobes and parallel valid/ready output of s2p.
//   shift_en, serial_data_in, frame_sync : serial side (into the receiver)
//   data_out, data_valid, data_ready     : parallel holding-register handshake
//   overrun, parity_err                  : 1-cycle status pulses
// Modports: master = link/consumer side (bench), slave = receiver (s2p).
// -----------------------------------------------------------------------------
interface s2p_if #(
  parameter int WIDTH = 8
);
  logic             shift_en;
  logic             serial_data_in;
  logic             frame_sync;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             overrun;
  logic             parity_err;

  modport master (
    output shift_en, serial_data_in, frame_sync, data_ready,
    input  data_out, data_valid, overrun, parity_err
  );

  modport slave (
    input  shift_en, serial_data_in, frame_sync, data_ready,
    output data_out, data_valid, overrun, parity_err
  );
endinterface

// File: rtl/s2p_out_buf.sv
// -----------------------------------------------------------------------------
// s2p_out_buf : WIDTH-bit valid/ready holding register for completed words.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   load_en            : a word completed this cycle
//   load_data          : the completed word
//   load_perr          : parity mismatch flag for the completed word
//   data_ready         : consumer accepts when data_valid && data_ready
//   data_out           : held word, stable while data_valid = 1
//   data_valid         : holding register occupied
//   overrun            : 1-cycle pulse, new word dropped (register full)
//   parity_err         : 1-cycle pulse on the edge a mismatching word loads
// -----------------------------------------------------------------------------
module s2p_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_perr,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun,
  output logic             parity_err
);

  logic [WIDTH-1:0] data_out_r;
  logic             data_valid_r;
  logic             overrun_r;
  logic             parity_err_r;

  // Holding register, handshake and status pulses.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      data_out_r   <= {WIDTH{1'b0}};
      data_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      overrun_r    <= 1'b0;
      parity_err_r <= 1'b0;
      if (load_en) begin
        // A full register that is not being drained this cycle keeps its
        // word; the new one is lost and flagged. A simultaneous accept frees
        // the slot, so the new word loads and valid stays high.
        if (data_valid_r && !data_ready) begin
          overrun_r <= 1'b1;
        end else begin
          data_out_r   <= load_data;
          data_valid_r <= 1'b1;
          parity_err_r <= load_perr;
        end
      end else if (data_valid_r && data_ready) begin
        data_valid_r <= 1'b0;
      end else begin
        data_valid_r <= data_valid_r;
      end
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign overrun    = overrun_r;
  assign parity_err = parity_err_r;

endmodule

// File: rtl/s2p.sv
// -----------------------------------------------------------------------------
// s2p : serial-to-parallel deserializer, receive end of the p2s link.
//   Samples serial_data_in on each shift_en strobe, LSB first; frame_sync
//   (qualified by shift_en) marks bit 0. Completed WIDTH-bit words are handed
//   to s2p_out_buf, which presents them on a valid/ready register.
// Ports:
//   sys_clk   : system clock, rising edge
//   sys_rst_n : synchronous active-low reset
//   bus       : s2p_if.slave (serial strobes in, parallel word/status out)
// Configuration:
//   S2P_PARITY_EN : when defined, an even-parity bit follows each word and a
//                   mismatch pulses parity_err; otherwise parity_err is 0.
// -----------------------------------------------------------------------------
module s2p #(
  parameter int WIDTH = 8
) (
  input  logic   sys_clk,
  input  logic   sys_rst_n,
  s2p_if.slave   bus
);
  import s2p_pkg::*;

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] shift_r, shift_nxt_s;
  logic             par_r, par_nxt_s;
  logic             done_s;
  logic [WIDTH-1:0] word_s;
  logic             perr_s;

  // FSM state, bit counter, shift register and running parity.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      shift_r <= {WIDTH{1'b0}};
      par_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      shift_r <= shift_nxt_s;
      par_r   <= par_nxt_s;
    end
  end

  // Next-state logic and word-completion strobe.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    shift_nxt_s = shift_r;
    par_nxt_s   = par_r;
    done_s      = 1'b0;
    word_s      = shift_r;
    perr_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.shift_en && bus.frame_sync) begin
          shift_nxt_s = WIDTH'(bus.serial_data_in);
          cnt_nxt_s   = CNT_ONE;
          par_nxt_s   = bus.serial_data_in;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (bus.shift_en && bus.frame_sync) begin
          // Resync: this bit starts a new frame, the partial word is lost.
          shift_nxt_s = WIDTH'(bus.serial_data_in);
          cnt_nxt_s   = CNT_ONE;
          par_nxt_s   = bus.serial_data_in;
          state_nxt_s = SHIFT;
        end else if (bus.shift_en) begin
          shift_nxt_s[cnt_r] = bus.serial_data_in;
          par_nxt_s          = par_r ^ bus.serial_data_in;
          if (cnt_r == LAST_CNT) begin
            cnt_nxt_s = {CNT_W{1'b0}};
`ifdef S2P_PARITY_EN
            state_nxt_s = PARITY;
`else
            done_s      = 1'b1;
            word_s      = shift_nxt_s;
            state_nxt_s = IDLE;
`endif
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          state_nxt_s = SHIFT;
        end
      end
`ifdef S2P_PARITY_EN
      PARITY: begin
        if (bus.shift_en && bus.frame_sync) begin
          shift_nxt_s = WIDTH'(bus.serial_data_in);
          cnt_nxt_s   = CNT_ONE;
          par_nxt_s   = bus.serial_data_in;
          state_nxt_s = SHIFT;
        end else if (bus.shift_en) begin
          // par_r holds XOR of the data bits; even parity makes the total 0.
          done_s      = 1'b1;
          word_s      = shift_r;
          perr_s      = par_r ^ bus.serial_data_in;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PARITY;
        end
      end
`endif
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
        shift_nxt_s = {WIDTH{1'b0}};
        par_nxt_s   = 1'b0;
      end
    endcase
  end

  s2p_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .load_en    (done_s),
    .load_data  (word_s),
    .load_perr  (perr_s),
    .data_ready (bus.data_ready),
    .data_out   (bus.data_out),
    .data_valid (bus.data_valid),
    .overrun    (bus.overrun),
    .parity_err (bus.parity_err)
  );

endmodule

// File: tb/tb_s2p.sv
// -----------------------------------------------------------------------------
// tb_s2p : self-checking bench for s2p. Stimulus pushes expected words into a
// queue; a monitor pops and compares on every accepted word. Directed checks
// cover reset, latency, overrun, resync and (with S2P_PARITY_EN) parity.
// -----------------------------------------------------------------------------
module tb_s2p;
  localparam int WIDTH = 8;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  s2p_if #(.WIDTH(WIDTH)) bus ();

  s2p #(.WIDTH(WIDTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int         total      = 0;
  int         bad        = 0;
  int         ov_count   = 0;
  int         perr_count = 0;
  logic       perr_seen  = 1'b0;
  logic [8:0] exp_q[$];   // {expected parity_err, expected word}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge sys_clk) begin
    logic [8:0] e;
    if (!sys_rst_n) begin
      perr_seen = 1'b0;
    end else begin
      if (bus.overrun) ov_count++;
      if (bus.parity_err) begin
        perr_seen = 1'b1;
        perr_count++;
      end
      if (bus.data_valid && bus.data_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(bus.data_out), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", 32'(bus.data_out), 32'(e[7:0]));
          chk("word_perr", 32'(perr_seen), 32'(e[8]));
          perr_seen = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic en, input logic b, input logic fs);
    bus.shift_en       = en;
    bus.serial_data_in = b;
    bus.frame_sync     = fs;
    @(posedge sys_clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  // n bits of w, LSB first; gap off-strobe cycles (with junk data and a
  // spurious frame_sync) precede each strobe.
  task automatic send_bits(input logic [7:0] w, input int n, input int gap, input logic use_fs);
    for (int i = 0; i < n; i++) begin
      repeat (gap) drive(1'b0, ~w[i], 1'b1);
      drive(1'b1, w[i], 1'(i == 0 && use_fs));
    end
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    send_bits(w, 8, gap, 1'b1);
`ifdef S2P_PARITY_EN
    repeat (gap) drive(1'b0, ^w, 1'b1);
    drive(1'b1, ^w, 1'b0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.shift_en       = 1'b0;
    bus.serial_data_in = 1'b0;
    bus.frame_sync     = 1'b0;
    bus.data_ready     = 1'b1;
    @(posedge sys_clk);
    #2;
    idle(2);
    chk("rst_valid",   32'(bus.data_valid), 32'd0);
    chk("rst_data",    32'(bus.data_out),   32'd0);
    chk("rst_overrun", 32'(bus.overrun),    32'd0);
    chk("rst_perr",    32'(bus.parity_err), 32'd0);
    sys_rst_n = 1'b1;
    idle(1);

    // 1: 0xA5, strobe every cycle, ready high.
    chk("t1_valid_before", 32'(bus.data_valid), 32'd0);
    exp_q.push_back({1'b0, 8'hA5});
    send_word(8'hA5, 0);
    chk("t1_latency", 32'(bus.data_valid), 32'd1);
    chk("t1_data",    32'(bus.data_out),   32'hA5);
    idle(1);
    chk("t1_valid_low", 32'(bus.data_valid), 32'd0);

    // 2: same frame, strobe every third cycle with toggling junk.
    exp_q.push_back({1'b0, 8'hA5});
    send_word(8'hA5, 2);
    chk("t2_data", 32'(bus.data_out), 32'hA5);
    idle(2);

    // 3: ready low, back-to-back 0x3C then 0xC3 -> overrun.
    bus.data_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h3C});
    send_word(8'h3C, 0);
    chk("t3_first_valid", 32'(bus.data_valid), 32'd1);
    send_word(8'hC3, 0);
    chk("t3_overrun", 32'(bus.overrun),  32'd1);
    chk("t3_hold",    32'(bus.data_out), 32'h3C);
    idle(1);
    chk("t3_ov_pulse", 32'(bus.overrun),  32'd0);
    chk("t3_hold2",    32'(bus.data_out), 32'h3C);
    bus.data_ready = 1'b1;
    idle(1);
    chk("t3_release", 32'(bus.data_valid), 32'd0);

    // 4: resync after 4 bits, then full 0x81.
    exp_q.push_back({1'b0, 8'h81});
    send_bits(8'h0F, 4, 0, 1'b1);
    send_word(8'h81, 0);
    chk("t4_valid", 32'(bus.data_valid), 32'd1);
    chk("t4_data",  32'(bus.data_out),   32'h81);
    idle(2);
    chk("t4_no_ov", 32'(ov_count), 32'd1);

    // 5: reset one cycle after bit 5, then unsynced bits, then 0x5A.
    send_bits(8'hFF, 5, 0, 1'b1);
    idle(1);
    sys_rst_n = 1'b0;
    idle(1);
    chk("t5_valid",   32'(bus.data_valid), 32'd0);
    chk("t5_data",    32'(bus.data_out),   32'd0);
    chk("t5_overrun", 32'(bus.overrun),    32'd0);
    chk("t5_perr",    32'(bus.parity_err), 32'd0);
    sys_rst_n = 1'b1;
    send_bits(8'hFF, 3, 0, 1'b0);
    exp_q.push_back({1'b0, 8'h5A});
    send_word(8'h5A, 0);
    chk("t5_new_data", 32'(bus.data_out), 32'h5A);
    idle(2);

`ifdef S2P_PARITY_EN
    // 6: good and bad parity on 0xA5.
    exp_q.push_back({1'b0, 8'hA5});
    send_bits(8'hA5, 8, 0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    chk("t6_good_valid", 32'(bus.data_valid), 32'd1);
    chk("t6_good_perr",  32'(bus.parity_err), 32'd0);
    idle(1);
    exp_q.push_back({1'b1, 8'hA5});
    send_bits(8'hA5, 8, 0, 1'b1);
    chk("t6_not_yet", 32'(bus.data_valid), 32'd0);
    drive(1'b1, 1'b1, 1'b0);
    chk("t6_bad_perr",  32'(bus.parity_err), 32'd1);
    chk("t6_bad_valid", 32'(bus.data_valid), 32'd1);
    chk("t6_bad_data",  32'(bus.data_out),   32'hA5);
    idle(1);
    chk("t6_perr_pulse", 32'(bus.parity_err), 32'd0);
    idle(1);
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge sys_clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("overrun_count", 32'(ov_count),     32'd1);
`ifdef S2P_PARITY_EN
    chk("perr_count", 32'(perr_count), 32'd1);
`else
    chk("perr_count", 32'(perr_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
